// File: rtl/gmii_mii_tx_adapter.sv
// Byte-stream to GMII/MII transmit adapter: byte or nibble serialisation, tx_er on
// underflow, enforced inter-frame gap and a synchronised TX reset output.
module gmii_mii_tx_adapter #(
  parameter int RST_SYNC_STAGES = 4,
  parameter int MIN_IFG         = 12,
  parameter int ENABLE_MII      = 1
) (
  input  logic       mac_gmii_tx_clk,
  input  logic       rst,
  output logic       tx_rst,
  input  logic       mii_select,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic       s_tuser,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       underflow,
  output logic       busy
);

  localparam int CW = $clog2(2 * MIN_IFG + 1);
  localparam logic [CW-1:0] IFG_GMII = CW'(MIN_IFG);
  localparam logic [CW-1:0] IFG_MII  = CW'(2 * MIN_IFG);

  typedef enum logic [1:0] {IDLE, DATA, ERR_DRAIN, IFG} state_t;

  logic [RST_SYNC_STAGES-1:0] rst_sync_q;
  state_t                     state_q, state_d;
  logic                       mode_q, mode_d;
  logic                       phase_q, phase_d;
  logic [7:0]                 hold_q, hold_d;
  logic                       hold_er_q, hold_er_d;
  logic                       last_q, last_d;
  logic                       uf_pend_q, uf_pend_d;
  logic [CW-1:0]              ifg_cnt_q, ifg_cnt_d;
  logic [7:0]                 txd_q, txd_d;
  logic                       tx_en_q, tx_en_d;
  logic                       tx_er_q, tx_er_d;
  logic                       underflow_q, underflow_d;
  logic                       mii_now;

  always_ff @(posedge mac_gmii_tx_clk or posedge rst) begin
    if (rst) rst_sync_q <= '1;
    else     rst_sync_q <= {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b0};
  end

  assign tx_rst     = rst_sync_q[RST_SYNC_STAGES-1];
  assign mii_now    = (ENABLE_MII != 0) && mii_select;
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign underflow  = underflow_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    hold_er_d   = hold_er_q;
    last_d      = last_q;
    uf_pend_d   = uf_pend_q;
    ifg_cnt_d   = ifg_cnt_q;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    underflow_d = 1'b0;
    s_tready    = 1'b0;
    if (tx_rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          s_tready = 1'b1;
          if (s_tvalid) begin
            mode_d    = mii_now;
            hold_d    = s_tdata;
            hold_er_d = s_tuser;
            last_d    = s_tlast;
            uf_pend_d = 1'b0;
            tx_en_d   = 1'b1;
            tx_er_d   = s_tuser;
            if (mii_now) begin
              txd_d   = {4'h0, s_tdata[3:0]};
              phase_d = 1'b1;
              state_d = DATA;
            end else begin
              txd_d     = s_tdata;
              state_d   = s_tlast ? IFG : DATA;
              ifg_cnt_d = IFG_GMII;
            end
          end
        end
        DATA: begin
          if (!mode_q) begin
            s_tready = 1'b1;
            tx_en_d  = 1'b1;
            if (s_tvalid) begin
              txd_d   = s_tdata;
              tx_er_d = s_tuser;
              if (s_tlast) begin
                state_d   = IFG;
                ifg_cnt_d = IFG_GMII;
              end
            end else begin
              tx_er_d     = 1'b1;
              underflow_d = 1'b1;
              state_d     = ERR_DRAIN;
            end
          end else if (!phase_q) begin
            // Low-nibble slot: either the next byte's low nibble or the deferred error symbol.
            tx_en_d = 1'b1;
            phase_d = 1'b1;
            if (uf_pend_q) begin
              tx_er_d     = 1'b1;
              underflow_d = 1'b1;
              uf_pend_d   = 1'b0;
              state_d     = ERR_DRAIN;
            end else begin
              txd_d   = {4'h0, hold_q[3:0]};
              tx_er_d = hold_er_q;
            end
          end else begin
            txd_d   = {4'h0, hold_q[7:4]};
            tx_en_d = 1'b1;
            tx_er_d = hold_er_q;
            if (last_q) begin
              state_d   = IFG;
              ifg_cnt_d = IFG_MII;
            end else begin
              s_tready = 1'b1;
              phase_d  = 1'b0;
              if (s_tvalid) begin
                hold_d    = s_tdata;
                hold_er_d = s_tuser;
                last_d    = s_tlast;
              end else begin
                uf_pend_d = 1'b1;
              end
            end
          end
        end
        ERR_DRAIN: begin
          s_tready = 1'b1;
          if (s_tvalid && s_tlast) begin
            state_d   = IFG;
            ifg_cnt_d = mode_q ? IFG_MII : IFG_GMII;
          end
        end
        IFG: begin
          if (ifg_cnt_q <= CW'(1)) state_d = IDLE;
          else                     ifg_cnt_d = ifg_cnt_q - CW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge mac_gmii_tx_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      phase_q     <= 1'b0;
      hold_q      <= 8'h00;
      hold_er_q   <= 1'b0;
      last_q      <= 1'b0;
      uf_pend_q   <= 1'b0;
      ifg_cnt_q   <= '0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      hold_er_q   <= hold_er_d;
      last_q      <= last_d;
      uf_pend_q   <= uf_pend_d;
      ifg_cnt_q   <= ifg_cnt_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_gmii_mii_tx_adapter.sv
// Bench for gmii_mii_tx_adapter: directed vector table, randomized frames against a
// frame-level reference model, and hand sequences for reset behaviour.
module tb_gmii_mii_tx_adapter;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_rst;
  logic       mii_select;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic       s_tuser;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       underflow;
  logic       busy;

  gmii_mii_tx_adapter #(.RST_SYNC_STAGES(4), .MIN_IFG(12), .ENABLE_MII(1)) dut (
    .mac_gmii_tx_clk(clk), .rst(rst), .tx_rst(tx_rst), .mii_select(mii_select),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] txd; logic er; logic uf; } sym_t;
  typedef struct {
    bit mii; int len; logic [7:0] d0; logic [7:0] d1;
    int bub_at; int bub_len; int tuser_at; bit toggle;
    int exp_len; int exp_gap;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  sym_t exp_sym[$];
  int   exp_len[$];
  int   exp_req[$];
  int   obs_len[$];
  int   obs_gap[$];
  logic [7:0] fb[0:255];
  bit         fu[0:255];
  int         fbub[0:255];
  bit  mon_en = 1'b0;
  bit  in_burst;
  int  burst_cnt, gap_cnt, cur_req;
  bit  cur_req_v;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Frame-level reference: one symbol per byte (GMII) or two per byte (MII), cut short by
  // an error symbol at the first byte the source fails to offer when it is asked for one.
  function automatic void model_frame(input bit mii, input int len);
    int k = len;
    int n = 0;
    for (int i = 1; i < len; i++)
      if (k == len && fbub[i] >= ((mii && i >= 2) ? 2 : 1)) k = i;
    for (int i = 0; i < k; i++) begin
      if (mii) begin
        exp_sym.push_back({4'h0, fb[i][3:0], fu[i], 1'b0});
        exp_sym.push_back({4'h0, fb[i][7:4], fu[i], 1'b0});
        n += 2;
      end else begin
        exp_sym.push_back({fb[i], fu[i], 1'b0});
        n += 1;
      end
    end
    if (k < len) begin
      exp_sym.push_back({8'h00, 1'b1, 1'b1});
      n += 1;
    end
    exp_len.push_back(n);
    exp_req.push_back(mii ? 24 : 12);
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_burst = 1'b0; gap_cnt = 0; cur_req_v = 1'b0;
        continue;
      end
      if (gmii_tx_en) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          burst_cnt = 0;
          obs_gap.push_back(gap_cnt);
          if (cur_req_v) chk(gap_cnt >= cur_req, "ifg_min", gap_cnt, cur_req);
        end
        burst_cnt++;
        if (exp_sym.size() == 0) chk(1'b0, "sym_extra", int'(gmii_txd), 0);
        else begin
          sym_t e = exp_sym.pop_front();
          chk({gmii_txd, gmii_tx_er, underflow} == e, "sym",
              int'({gmii_txd, gmii_tx_er, underflow}), int'(e));
        end
      end else begin
        if (in_burst) begin
          in_burst = 1'b0;
          obs_len.push_back(burst_cnt);
          if (exp_len.size() > 0) begin
            int el = exp_len.pop_front();
            chk(burst_cnt == el, "burst_len", burst_cnt, el);
          end
          if (exp_req.size() > 0) begin cur_req = exp_req.pop_front(); cur_req_v = 1'b1; end
          gap_cnt = 0;
        end
        gap_cnt++;
        chk({gmii_txd, gmii_tx_er, underflow} == 10'd0, "idle_out",
            int'({gmii_txd, gmii_tx_er, underflow}), 0);
      end
    end
  endtask

  task automatic send_frame(input bit mii, input int len, input bit toggle);
    model_frame(mii, len);
    for (int i = 0; i < len; i++) begin
      int n = 0;
      for (int b = 0; b < fbub[i]; b++) begin
        @(negedge clk);
        s_tvalid = 1'b0;
        if (i == 0) mii_select = mii;
      end
      @(negedge clk);
      if (i == 0) mii_select = mii;
      if (toggle && i == len / 2) mii_select = ~mii;
      s_tvalid = 1'b1; s_tdata = fb[i]; s_tuser = fu[i]; s_tlast = (i == len - 1);
      #4;
      while (!s_tready && n < 500) begin
        @(negedge clk); #4; n++;
      end
      if (n >= 500) chk(1'b0, "accept_timeout", n, 0);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_sym.size() != 0 || busy || in_burst) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk(n < 3000, "drain_timeout", n, 3000);
    repeat (2) @(negedge clk);
  endtask

  task automatic rst_release();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk(tx_rst == (k < 4), "tx_rst_hold", int'(tx_rst), int'(k < 4));
      chk(s_tready == (k >= 4), "tready_after_rst", int'(s_tready), int'(k >= 4));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({gmii_txd, gmii_tx_en, gmii_tx_er, underflow} == 11'd0, tag,
        int'({gmii_txd, gmii_tx_en, gmii_tx_er, underflow}), 0);
    chk(tx_rst == 1'b1, "rst_tx_rst", int'(tx_rst), 1);
    chk(s_tready == 1'b0, "rst_tready", int'(s_tready), 0);
    chk(busy == 1'b0, "rst_busy", int'(busy), 0);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 64, 8'h00, 8'h01, -1, 0, -1, 0, 64, 12};
    tbl[1] = '{1,  2, 8'hA5, 8'h3C, -1, 0, -1, 0,  4, 24};
    tbl[2] = '{0, 20, 8'h00, 8'h01, 10, 3, -1, 0, 11, 24};
    tbl[3] = '{0,  8, 8'h10, 8'h11, -1, 0,  5, 0,  8, 12};
    tbl[4] = '{1,  8, 8'h20, 8'h21, -1, 0,  5, 0, 16, 24};
    tbl[5] = '{1,  6, 8'h30, 8'h31,  3, 1, -1, 0, 12, 24};
    tbl[6] = '{1,  6, 8'h40, 8'h41,  3, 2, -1, 0,  7, 27};
    tbl[7] = '{0,  1, 8'h77, 8'h00, -1, 0, -1, 0,  1, 12};
    tbl[8] = '{1,  1, 8'h96, 8'h00, -1, 0, -1, 0,  2, 24};
    tbl[9] = '{0, 10, 8'h50, 8'h51, -1, 0, -1, 1, 10, 12};

    rst = 1'b1; mii_select = 1'b0; s_tdata = 8'h00;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    fork monitor(); join_none
    #1;
    check_reset_outputs("reset_outputs");
    repeat (3) @(negedge clk);
    rst_release();
    mon_en = 1'b1;

    // Directed table: each case followed by a 1-byte GMII probe to measure the gap.
    obs_len.delete(); obs_gap.delete();
    foreach (tbl[v]) begin
      for (int i = 0; i < tbl[v].len; i++) begin
        fb[i]   = (i == 0) ? tbl[v].d0 : (i == 1) ? tbl[v].d1 : 8'(i);
        fu[i]   = (i == tbl[v].tuser_at);
        fbub[i] = (i == tbl[v].bub_at) ? tbl[v].bub_len : 0;
      end
      send_frame(tbl[v].mii, tbl[v].len, tbl[v].toggle);
      fb[0] = 8'h5A; fu[0] = 1'b0; fbub[0] = 0;
      send_frame(1'b0, 1, 1'b0);
    end
    go_idle();
    wait_drain();
    chk(obs_len.size() == 20, "tbl_bursts", obs_len.size(), 20);
    foreach (tbl[v]) begin
      if (obs_len.size() > 2 * v + 1) begin
        chk(obs_len[2 * v] == tbl[v].exp_len, "tbl_len", obs_len[2 * v], tbl[v].exp_len);
        chk(obs_gap[2 * v + 1] == tbl[v].exp_gap, "tbl_gap", obs_gap[2 * v + 1], tbl[v].exp_gap);
      end
    end

    // Randomized frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      bit m = 1'($urandom_range(0, 1));
      int len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        fb[i]   = 8'($urandom);
        fu[i]   = ($urandom_range(0, 15) == 0);
        fbub[i] = ($urandom_range(0, 29) == 0) ? $urandom_range(1, 3) : 0;
      end
      send_frame(m, len, 1'b0);
    end
    go_idle();
    wait_drain();

    // Reset in the middle of a GMII frame.
    mon_en = 1'b0;
    @(negedge clk);
    mii_select = 1'b0; s_tvalid = 1'b1; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = 8'h80;
    repeat (5) begin @(negedge clk); s_tdata = s_tdata + 8'd1; end
    chk(gmii_tx_en == 1'b1, "pre_rst_en", int'(gmii_tx_en), 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midframe_rst_outputs");
    s_tvalid = 1'b0;
    exp_sym.delete(); exp_len.delete(); exp_req.delete();
    rst_release();
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin fb[i] = 8'hC0 + 8'(i); fu[i] = 1'b0; fbub[i] = 0; end
    send_frame(1'b0, 6, 1'b0);
    go_idle();
    wait_drain();
    chk(busy == 1'b0, "final_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
